// File: rtl/instruction_dispatcher.sv
// In-order instruction dispatcher: fetches one word at a time and issues it
// to the load, compute or store unit, tracking per-unit busy state.
module instruction_dispatcher #(
  parameter int width = 512,
  parameter int OPW   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   instruction_ready,
  input  logic                   instruction_valid,
  input  logic [width-1:0]       instruction,
  output logic                   ld_valid,
  input  logic                   ld_ready,
  output logic                   cp_valid,
  input  logic                   cp_ready,
  output logic                   st_valid,
  input  logic                   st_ready,
  output logic [width-OPW-1:0]   payload,
  input  logic                   ld_done,
  input  logic                   cp_done,
  input  logic                   st_done,
  output logic                   accelerator_busy,
  output logic [31:0]            retired,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, SYNC} state_t;

  localparam logic [OPW-1:0] OP_NOP     = OPW'(0);
  localparam logic [OPW-1:0] OP_LOAD    = OPW'(1);
  localparam logic [OPW-1:0] OP_COMPUTE = OPW'(2);
  localparam logic [OPW-1:0] OP_STORE   = OPW'(3);
  localparam logic [OPW-1:0] OP_SYNC    = OPW'(4);
  localparam logic [OPW-1:0] OP_END     = OPW'(5);

  state_t           state_reg, state_next;
  logic [width-1:0] instr_reg;
  logic             instr_load;
  logic [2:0]       busy_reg, busy_next;
  logic [31:0]      retired_reg, retired_next;
  logic             err_reg, err_next;
  logic [OPW-1:0]   opcode;
  logic [2:0]       unit_sel, unit_valid, unit_ready, unit_done, handshake;

  assign opcode     = instr_reg[width-1 -: OPW];
  assign unit_ready = {st_ready, cp_ready, ld_ready};
  assign unit_done  = {st_done, cp_done, ld_done};

  // Unit index: bit 0 load, bit 1 compute, bit 2 store.
  always_comb begin
    unit_sel = 3'b000;
    case (opcode)
      OP_LOAD:    unit_sel = 3'b001;
      OP_COMPUTE: unit_sel = 3'b010;
      OP_STORE:   unit_sel = 3'b100;
      default:    unit_sel = 3'b000;
    endcase
  end

  // Valid depends only on registered state and busy, so it cannot drop
  // before the handshake (busy only sets on our own handshake).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unit
      assign unit_valid[gi] = (state_reg == ISSUE) && unit_sel[gi] && !busy_reg[gi];
      assign handshake[gi]  = unit_valid[gi] && unit_ready[gi];
      assign busy_next[gi]  = handshake[gi] | (busy_reg[gi] & ~unit_done[gi]);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    retired_next = retired_reg;
    err_next     = err_reg;
    instr_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = FETCH;
          retired_next = 32'd0;
        end
      end
      FETCH: begin
        if (instruction_valid) begin
          instr_load = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_NOP: begin
            retired_next = retired_reg + 32'd1;
            state_next   = FETCH;
          end
          OP_LOAD, OP_COMPUTE, OP_STORE: state_next = ISSUE;
          OP_SYNC: state_next = SYNC;
          OP_END: begin
            retired_next = retired_reg + 32'd1;
            state_next   = IDLE;
          end
          default: begin
            err_next   = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      ISSUE: begin
        if (|handshake) begin
          retired_next = retired_reg + 32'd1;
          state_next   = FETCH;
        end
      end
      SYNC: begin
        if (busy_reg == 3'b000) begin
          retired_next = retired_reg + 32'd1;
          state_next   = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      instr_reg   <= '0;
      busy_reg    <= 3'b000;
      retired_reg <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      busy_reg    <= busy_next;
      retired_reg <= retired_next;
      err_reg     <= err_next;
      if (instr_load) instr_reg <= instruction;
    end
  end

  assign instruction_ready = (state_reg == FETCH);
  assign ld_valid          = unit_valid[0];
  assign cp_valid          = unit_valid[1];
  assign st_valid          = unit_valid[2];
  assign payload           = instr_reg[width-OPW-1:0];
  assign accelerator_busy  = busy_reg[0] | busy_reg[2] | unit_valid[0] | unit_valid[2];
  assign retired           = retired_reg;
  assign err               = err_reg;

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 SHALL have parameter width, default 512, instruction word width in bits.
REQ-002 SHALL have parameter OPW, default 4, opcode width taken from instruction[width-1 -: OPW].
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  start  in  1  one-cycle pulse, begin dispatching
  instruction_ready  out  1  request one instruction from the upstream queue
  instruction_valid  in  1  one-cycle pulse, instruction present
  instruction  in  width  instruction word
  ld_valid / ld_ready  out / in  1 / 1  load-unit issue handshake
  cp_valid / cp_ready  out / in  1 / 1  compute-unit issue handshake
  st_valid / st_ready  out / in  1 / 1  store-unit issue handshake
  payload  out  width-OPW  instruction[width-OPW-1:0], shared by all unit ports
  ld_done, cp_done, st_done  in  1 each  one-cycle unit-completion pulses
  accelerator_busy  out  1  load or store unit owns the AXI channel
  retired  out  32  count of instructions fully issued or consumed
  err  out  1  sticky illegal-opcode flag

Function
REQ-005 Opcodes SHALL be: 0 NOP, 1 LOAD, 2 COMPUTE, 3 STORE, 4 SYNC, 5 END; all other values are illegal.
REQ-006 FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, SYNC.
REQ-007 IDLE -> FETCH on start; start SHALL be ignored in every other state.
REQ-008 instruction_ready SHALL be 1 only in FETCH (decoded from the registered state).
REQ-009 In FETCH, on instruction_valid the dispatcher SHALL latch instruction into an internal register and go to DECODE the next cycle; instruction_valid outside FETCH SHALL be ignored.
REQ-010 In DECODE: NOP and illegal opcodes -> FETCH; LOAD/COMPUTE/STORE -> ISSUE; SYNC -> SYNC; END -> IDLE.
REQ-011 Illegal opcode SHALL set err=1, hold it until reset, and SHALL NOT increment retired.
REQ-012 NOP and END SHALL increment retired by 1 in DECODE.
REQ-013 Per-unit busy flags SHALL set on that unit's issue handshake and clear on its done pulse; when both occur in the same cycle, set wins.
REQ-014 In ISSUE, the target unit's valid SHALL assert only when that unit's busy flag is 0; other units' valids stay 0.
REQ-015 Once asserted, a unit valid and payload SHALL remain stable until ready is sampled high.
REQ-016 On the issue handshake (valid & ready), retired SHALL increment by 1 and the FSM SHALL go to FETCH next cycle.
REQ-017 SYNC SHALL wait until all three busy flags are 0, then increment retired and go to FETCH; exit latency is 1 cycle after the last done pulse.
REQ-018 accelerator_busy SHALL equal ld_busy | st_busy | ld_valid | st_valid.
REQ-019 retired SHALL wrap modulo 2^32 and clear on start accepted in IDLE.
REQ-020 A done pulse for a unit whose busy flag is 0 SHALL be ignored.
REQ-021 Processing SHALL be strictly in order: at most one latched instruction, with no fetch while in ISSUE or SYNC.

Reset
REQ-022 Reset SHALL force state=IDLE; instruction_ready=0; all unit valids=0; busy flags=0; payload=0; retired=0; err=0; accelerator_busy=0.
REQ-023 Reset asserted mid-issue SHALL drop the valids asynchronously; the dispatcher SHALL NOT re-issue after reset releases.

Verification
REQ-024 Sequence start, LOAD, COMPUTE, STORE, END with units ready=1 and done 3 cycles after issue -> exactly one handshake per port, retired=4, return to IDLE, err=0.
REQ-025 LOAD, then LOAD while ld_done is withheld 10 cycles -> second ld_valid stays 0 until the cycle after ld_done, and instruction_ready stays 0 throughout.
REQ-026 COMPUTE, SYNC, STORE with cp_done after 20 cycles -> st_valid is not asserted before SYNC exits 1 cycle after cp_done; retired=3 after the STORE handshake.
REQ-027 Opcode 0xF, then NOP -> err=1 sticky, retired increments by 1 (NOP only), FSM returns to FETCH after each.
REQ-028 st_ready=0 for 5 cycles on a STORE -> st_valid and payload stay stable, accelerator_busy=1, retired unchanged until the handshake.
REQ-029 Reset asserted while cp_valid=1 -> all outputs read their reset values immediately; after release the FSM stays in IDLE until start.
